mult_div_seq: RTL and testbench

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

---
 rtl/mult_div_seq.sv | 137 +++++++++++++
 tb/tb_mult_div_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers, mthi/mtlo backup and pipeline stall.
// The result is computed at issue and held until the fixed-latency countdown expires.
module mult_div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wd,
  input  logic        id_md_instr,
  input  logic        cancel,
  input  logic        restore,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {StIdle, StCalc} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] bk_hi_q, bk_hi_d, bk_lo_q, bk_lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        res_we_q, res_we_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] s_div_b, u_div_b, q_s, r_s, q_u, r_u;
  logic [31:0] calc_hi, calc_lo;
  logic        b_zero, s_ovf;

  assign b_zero = (src_b == 32'd0);
  assign s_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Divisor forced to 1 on zero/overflow: avoids undefined division and yields the
  // required 0x80000000 remainder-0 result for the overflow case directly.
  assign s_div_b = (b_zero || s_ovf) ? 32'd1 : src_b;
  assign u_div_b = b_zero ? 32'd1 : src_b;
  assign q_s     = $signed(src_a) / $signed(s_div_b);
  assign r_s     = $signed(src_a) % $signed(s_div_b);
  assign q_u     = src_a / u_div_b;
  assign r_u     = src_a % u_div_b;

  always_comb begin
    calc_hi = 32'd0;
    calc_lo = 32'd0;
    unique case (op)
      2'b00: {calc_hi, calc_lo} = prod_s;
      2'b01: {calc_hi, calc_lo} = prod_u;
      2'b10: begin calc_hi = r_s; calc_lo = q_s; end
      2'b11: begin calc_hi = r_u; calc_lo = q_u; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    bk_hi_d  = bk_hi_q;
    bk_lo_d  = bk_lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_we_d = res_we_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          res_hi_d = calc_hi;
          res_lo_d = calc_lo;
          res_we_d = !(op[1] && b_zero);
          cnt_d    = op[1] ? 4'd10 : 4'd5;
          state_d  = StCalc;
        end else if (hilo_we != 2'b00 && !restore) begin
          bk_hi_d = hi_q;
          bk_lo_d = lo_q;
          if (hilo_we[0]) hi_d = hilo_wd;
          if (hilo_we[1]) lo_d = hilo_wd;
        end
      end
      StCalc: begin
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
          if (res_we_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
    if (restore) begin
      hi_d = bk_hi_q;
      lo_d = bk_lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      bk_hi_q  <= 32'd0;
      bk_lo_q  <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      bk_hi_q  <= bk_hi_d;
      bk_lo_q  <= bk_lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_we_q <= res_we_d;
    end
  end

  assign busy     = (state_q == StCalc);
  assign md_stall = id_md_instr & (busy | start);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: table of arithmetic vectors plus hand-written
// sequences for cancel, restore, ignored requests, stall and asynchronous reset.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset, start, id_md_instr, cancel, restore;
  logic [1:0]  op, hilo_we;
  logic [31:0] src_a, src_b, hilo_wd;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mult_div_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_we(hilo_we), .hilo_wd(hilo_wd), .id_md_instr(id_md_instr), .cancel(cancel),
    .restore(restore), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and count the cycles busy stays high (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    vecs[0] = '{"mult_neg2x3",   2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{"multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2] = '{"mult_min_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[3] = '{"multu_small",   2'b01, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 5};
    vecs[4] = '{"divu_100_7",    2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        10};
    vecs[5] = '{"div_m7_2",      2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[6] = '{"div_7_m2",      2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[7] = '{"div_ovf",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[8] = '{"divu_max_2",    2'b11, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF, 10};

    reset = 1'b1; start = 1'b1; id_md_instr = 1'b1; cancel = 1'b0; restore = 1'b0;
    op = 2'b00; src_a = 32'd0; src_b = 32'd0; hilo_we = 2'b00; hilo_wd = 32'd0;
    #2;
    chk("rst_stall_start", {31'd0, md_stall}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    start = 1'b0;
    id_md_instr = 1'b0;
    #1;
    chk("rst_stall_idle", {31'd0, md_stall}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk({vecs[i].name, "_cycles"}, n, vecs[i].cyc);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
    end

    // divu with a second start and an mthi/mtlo attempted mid-calculation
    op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == 4) begin
        op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
      end else if (n == 5) begin
        start = 1'b0; hilo_we = 2'b11; hilo_wd = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; hilo_we = 2'b00;
      end
      tick();
    end
    start = 1'b0; hilo_we = 2'b00;
    chk("ign_cycles", n, 32'd10);
    chk("ign_hi", hi, 32'd2);
    chk("ign_lo", lo, 32'd14);
    tick();
    chk("ign_no_restart", {31'd0, busy}, 32'd0);

    // mthi / mtlo preload
    hilo_we = 2'b01; hilo_wd = 32'h11;
    tick();
    chk("mthi_hi", hi, 32'h11);
    chk("mthi_lo_kept", lo, 32'd14);
    hilo_we = 2'b10; hilo_wd = 32'h22;
    tick();
    hilo_we = 2'b00;
    chk("mtlo_lo", lo, 32'h22);

    run_op(2'b10, 32'd55, 32'd0, n);
    chk("dz_cycles", n, 32'd10);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    // start and mthi/mtlo together: the write is dropped
    op = 2'b00; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    hilo_we = 2'b11; hilo_wd = 32'h0BAD;
    tick();
    start = 1'b0; hilo_we = 2'b00;
    chk("sw_drop_hi", hi, 32'h11);
    n = 1;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    chk("sw_hi", hi, 32'd0);
    chk("sw_lo", lo, 32'd6);

    // cancel on cycle 3 of a mult
    hilo_we = 2'b10; hilo_wd = 32'd5;
    tick();
    hilo_we = 2'b00;
    op = 2'b00; src_a = 32'd4; src_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("cancel_busy_before", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy_after", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("cancel_lo", lo, 32'd5);
    chk("cancel_hi", hi, 32'd0);

    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_idle_busy", {31'd0, busy}, 32'd0);
    chk("cancel_idle_lo", lo, 32'd5);

    // restore
    hilo_we = 2'b01; hilo_wd = 32'hA;
    tick();
    hilo_wd = 32'hB;
    tick();
    hilo_we = 2'b00;
    chk("rs_mthi_b", hi, 32'hB);
    restore = 1'b1;
    tick();
    restore = 1'b0;
    chk("rs_hi", hi, 32'hA);
    chk("rs_lo", lo, 32'd5);
    hilo_we = 2'b01; hilo_wd = 32'hC; restore = 1'b1;
    tick();
    hilo_we = 2'b00; restore = 1'b0;
    chk("rs_prio_hi", hi, 32'hA);

    // stall throughout busy, then async reset on calc cycle 2
    id_md_instr = 1'b1;
    op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
    #1;
    chk("stall_start", {31'd0, md_stall}, 32'd1);
    tick();
    start = 1'b0;
    chk("stall_c1", {31'd0, md_stall}, 32'd1);
    tick();
    chk("stall_c2", {31'd0, md_stall}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_stall", {31'd0, md_stall}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("arst_no_write_lo", lo, 32'd0);
    chk("arst_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
